// File: rtl/axi_wm_pkg.sv
// Shared types and constants for the AXI4 write master: FSM states, response
// codes, burst type and the 4 KB boundary arithmetic.
package axi_wm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RESP   = 2'd2,
    ST_REJECT = 2'd3
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] RESP_REJECT = 2'b11;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  // Width of the byte-lane offset inside one data word (at least one bit).
  function automatic int off_w(input int data_width);
    return (data_width > 8) ? $clog2(data_width / 8) : 1;
  endfunction

  // Byte just past the burst, measured from the start of its 4 KB page.
  function automatic logic [17:0] burst_end(input logic [11:0] addr,
                                            input logic [7:0]  len,
                                            input logic [2:0]  size);
    return {6'd0, addr} + ({9'd0, {1'b0, len} + 9'd1} << size);
  endfunction

endpackage

// File: rtl/axi_wstrb_gen.sv
// Write-strobe generator: enables the 2**size byte lanes of the aligned chunk
// that contains the current beat's byte offset.
module axi_wstrb_gen
  import axi_wm_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [off_w(DATA_WIDTH)-1:0] i_off,
  input  logic [2:0]                   i_size,
  output logic [DATA_WIDTH/8-1:0]      o_strb
);

  localparam int STRB_W = DATA_WIDTH / 8;

  // A lane is on when it falls in the same 2**size-aligned chunk as the offset.
  always_comb begin
    o_strb = '0;
    for (int b = 0; b < STRB_W; b++) begin
      if (STRB_W == 1) begin
        o_strb[b] = 1'b1;
      end else begin
        o_strb[b] = ((b >> i_size) == (int'(i_off) >> i_size));
      end
    end
  end

endmodule

// File: rtl/axi_write_master.sv
// AXI4 INCR write master: turns a command plus a beat stream into one burst on
// AW/W/B, rejects illegal commands locally and times out a missing response.
module axi_write_master
  import axi_wm_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 256
) (
  input  logic                    clk,
  input  logic                    ARESET,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]              cmd_len,
  input  logic [2:0]              cmd_size,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  output logic                    done_valid,
  output logic [1:0]              done_resp,
  output logic                    done_timeout,
  output logic [ADDR_WIDTH-1:0]   AWADDR,
  output logic [7:0]              AWLEN,
  output logic [2:0]              AWSIZE,
  output logic [1:0]              AWBURST,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic [DATA_WIDTH/8-1:0] WSTRB,
  output logic                    WLAST,
  output logic                    WVALID,
  input  logic                    WREADY,
  input  logic [1:0]              BRESP,
  input  logic                    BVALID,
  output logic                    BREADY
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = off_w(DATA_WIDTH);
  localparam int TO_W   = $clog2(TIMEOUT + 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_awvalid;
  logic                  r_aw_done;
  logic                  r_w_done;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [7:0]            r_awlen;
  logic [2:0]            r_awsize;
  logic [7:0]            r_beats;
  logic [OFF_W-1:0]      r_off;
  logic [TO_W-1:0]       r_to_cnt;
  logic                  r_done_valid;
  logic [1:0]            r_done_resp;
  logic                  r_done_timeout;

  logic                  w_active;
  logic                  w_cmd_hs;
  logic                  w_cmd_legal;
  logic [7:0]            w_bytes;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_last_hs;
  logic                  w_b_hs;
  logic                  w_timeout;
  logic [OFF_W-1:0]      w_off_inc;
  logic [STRB_W-1:0]     w_strb;

  assign w_active    = (r_state == ST_ACTIVE);
  assign cmd_ready   = (r_state == ST_IDLE) && !ARESET;
  assign w_cmd_hs    = cmd_valid && cmd_ready;
  assign w_bytes     = 8'd1 << cmd_size;
  assign w_cmd_legal = (w_bytes <= 8'(STRB_W)) &&
                       (burst_end(cmd_addr[11:0], cmd_len, cmd_size) <= 18'd4096);

  // W is a pass-through while a burst is open and its last beat is still owed.
  assign WVALID    = wr_valid && w_active && !r_w_done;
  assign wr_ready  = WREADY && w_active && !r_w_done;
  assign WDATA     = w_active ? wr_data : '0;
  assign WSTRB     = w_active ? w_strb : '0;
  assign WLAST     = w_active && !r_w_done && (r_beats == 8'd0);
  assign w_w_hs    = WVALID && WREADY;
  assign w_last_hs = w_w_hs && (r_beats == 8'd0);
  assign w_aw_hs   = r_awvalid && AWREADY;
  assign w_off_inc = OFF_W'(32'd1 << r_awsize);

  assign BREADY    = (r_state == ST_RESP);
  assign w_b_hs    = BREADY && BVALID;
  assign w_timeout = BREADY && !BVALID && (r_to_cnt == TO_W'(TIMEOUT - 1));

  assign AWADDR       = r_awaddr;
  assign AWLEN        = r_awlen;
  assign AWSIZE       = r_awsize;
  assign AWBURST      = BURST_INCR;
  assign AWVALID      = r_awvalid;
  assign done_valid   = r_done_valid;
  assign done_resp    = r_done_resp;
  assign done_timeout = r_done_timeout;

  axi_wstrb_gen #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_wstrb (
    .i_off  (r_off),
    .i_size (r_awsize),
    .o_strb (w_strb)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge ARESET) begin
    if (ARESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_cmd_hs) begin
          w_state_nxt = w_cmd_legal ? ST_ACTIVE : ST_REJECT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if ((w_last_hs || r_w_done) && (r_aw_done || w_aw_hs)) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_ACTIVE;
        end
      end
      ST_RESP: begin
        if (w_b_hs || w_timeout) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_REJECT: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Burst bookkeeping: AW fields, beat counter/offset, timeout and completion.
  always_ff @(posedge clk or posedge ARESET) begin
    if (ARESET) begin
      r_awvalid      <= 1'b0;
      r_aw_done      <= 1'b0;
      r_w_done       <= 1'b0;
      r_awaddr       <= '0;
      r_awlen        <= 8'd0;
      r_awsize       <= 3'd0;
      r_beats        <= 8'd0;
      r_off          <= '0;
      r_to_cnt       <= '0;
      r_done_valid   <= 1'b0;
      r_done_resp    <= 2'b00;
      r_done_timeout <= 1'b0;
    end else begin
      r_done_valid   <= 1'b0;
      r_done_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_cmd_hs && w_cmd_legal) begin
            r_awaddr  <= cmd_addr;
            r_awlen   <= cmd_len;
            r_awsize  <= cmd_size;
            r_awvalid <= 1'b1;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_beats   <= cmd_len;
            r_off     <= cmd_addr[OFF_W-1:0];
            r_to_cnt  <= '0;
          end else if (w_cmd_hs) begin
            r_done_valid <= 1'b1;
            r_done_resp  <= RESP_REJECT;
          end
        end
        ST_ACTIVE: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_off <= r_off + w_off_inc;
            if (r_beats == 8'd0) begin
              r_w_done <= 1'b1;
            end else begin
              r_beats <= r_beats - 8'd1;
            end
          end
        end
        ST_RESP: begin
          if (w_b_hs) begin
            r_done_valid <= 1'b1;
            r_done_resp  <= BRESP;
          end else if (w_timeout) begin
            r_done_valid   <= 1'b1;
            r_done_resp    <= RESP_SLVERR;
            r_done_timeout <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        ST_REJECT: r_done_valid <= 1'b0;
        default:   r_done_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_write_master.sv
// Bench for axi_write_master: a transaction-level model predicts AW, W and
// completion traffic per command and a monitor compares every handshake.
module tb_axi_write_master;

  logic        clk = 1'b0;
  logic        ARESET;
  logic        cmd_valid, cmd_ready;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [31:0] wr_data;
  logic        wr_valid, wr_ready;
  logic        done_valid, done_timeout;
  logic [1:0]  done_resp;
  logic [15:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID, AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST, WVALID, WREADY;
  logic [1:0]  BRESP;
  logic        BVALID, BREADY;

  axi_write_master #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
    .clk(clk), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_size(cmd_size),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .done_valid(done_valid), .done_resp(done_resp), .done_timeout(done_timeout),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] addr; logic [7:0] len; logic [2:0] size; } aw_t;
  typedef struct { logic [31:0] d; logic [3:0] s; logic l; } w_t;
  typedef struct { logic [1:0] r; logic t; } d_t;

  aw_t        exp_aw[$];
  w_t         exp_w[$];
  d_t         exp_done[$];
  logic [3:0] obs_strb[$];
  int         total = 0;
  int         bad = 0;
  int         n_aw = 0;
  int         n_done = 0;
  int         aw_w_pos = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] beat_data(input logic [31:0] seed, input int i);
    return seed + 32'h01010101 * 32'(i);
  endfunction

  // Model: from the command alone, predict the AW beat, every W beat and the completion.
  function automatic bit model_cmd(input logic [15:0] addr, input logic [7:0] len,
                                   input logic [2:0] size, input logic [31:0] seed,
                                   input int b_delay, input logic [1:0] bresp);
    int  bytes, nb, a, lo;
    aw_t ea;
    w_t  ew;
    d_t  ed;
    bytes = 1 << size;
    nb    = int'(len) + 1;
    if (bytes > 4 || (int'(addr) % 4096) + nb * bytes > 4096) begin
      ed.r = 2'b11; ed.t = 1'b0;
      exp_done.push_back(ed);
      return 1'b0;
    end
    ea.addr = addr; ea.len = len; ea.size = size;
    exp_aw.push_back(ea);
    for (int i = 0; i < nb; i++) begin
      a    = int'(addr) + i * bytes;
      lo   = (a % 4) - (a % bytes);
      ew.d = beat_data(seed, i);
      ew.s = 4'(((1 << bytes) - 1) << lo);
      ew.l = (i == nb - 1);
      exp_w.push_back(ew);
    end
    if (b_delay < 0) begin ed.r = 2'b10; ed.t = 1'b1; end
    else begin ed.r = bresp; ed.t = 1'b0; end
    exp_done.push_back(ed);
    return 1'b1;
  endfunction

  // Monitor: every AW/W handshake and every done pulse is checked against the model.
  always @(negedge clk) begin
    aw_t ea;
    w_t  ew;
    d_t  ed;
    if (!ARESET) begin
      if (AWVALID && AWREADY) begin
        n_aw++;
        aw_w_pos = obs_strb.size();
        chk("aw_pending", 32'(exp_aw.size() > 0), 32'd1);
        if (exp_aw.size() > 0) begin
          ea = exp_aw.pop_front();
          chk("awaddr", 32'(AWADDR), 32'(ea.addr));
          chk("awlen", 32'(AWLEN), 32'(ea.len));
          chk("awsize", 32'(AWSIZE), 32'(ea.size));
          chk("awburst", 32'(AWBURST), 32'd1);
        end
      end
      if (WVALID && WREADY) begin
        obs_strb.push_back(WSTRB);
        chk("w_pending", 32'(exp_w.size() > 0), 32'd1);
        if (exp_w.size() > 0) begin
          ew = exp_w.pop_front();
          chk("wdata", WDATA, ew.d);
          chk("wstrb", 32'(WSTRB), 32'(ew.s));
          chk("wlast", 32'(WLAST), 32'(ew.l));
        end
      end
      if (done_valid) begin
        n_done++;
        chk("done_pending", 32'(exp_done.size() > 0), 32'd1);
        if (exp_done.size() > 0) begin
          ed = exp_done.pop_front();
          chk("done_resp", 32'(done_resp), 32'(ed.r));
          chk("done_timeout", 32'(done_timeout), 32'(ed.t));
        end
      end
    end
  end

  task automatic do_cmd(input logic [15:0] addr, input logic [7:0] len, input logic [2:0] size,
                        input logic [31:0] seed, input int aw_delay, input logic [31:0] wmask,
                        input int b_delay, input logic [1:0] bresp, input int rst_after,
                        output int done_cyc);
    logic [31:0] src[$];
    int k, aw_cnt, b_cnt, popped, wait_n;
    bit legal;
    legal = model_cmd(addr, len, size, seed, b_delay, bresp);
    src = {};
    for (int i = 0; i <= int'(len); i++) src.push_back(beat_data(seed, i));
    obs_strb.delete();
    aw_w_pos = -1;
    cmd_addr = addr; cmd_len = len; cmd_size = size; cmd_valid = 1'b1;
    wait_n = 0;
    @(negedge clk);
    while (!cmd_ready && wait_n < 50) begin @(negedge clk); wait_n++; end
    chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    k = 1; aw_cnt = 0; b_cnt = 0; popped = 0; done_cyc = -1;
    while (k < 200) begin
      wr_valid = (src.size() > 0);
      wr_data  = (src.size() > 0) ? src[0] : 32'h0;
      WREADY   = wmask[5'(k % 32)];
      AWREADY  = (aw_cnt >= aw_delay);
      BVALID   = (b_delay >= 0) && (b_cnt >= b_delay);
      BRESP    = bresp;
      @(negedge clk);
      if (wr_valid && wr_ready) begin void'(src.pop_front()); popped++; end
      if (AWVALID) aw_cnt++;
      if (BREADY) b_cnt++;
      if (done_valid) begin done_cyc = k; break; end
      if (rst_after > 0 && popped == rst_after) begin
        @(posedge clk); #1;
        chk("awvalid_pre_rst", 32'(AWVALID), 32'd1);
        chk("wvalid_pre_rst", 32'(WVALID), 32'(wr_valid));
        #1 ARESET = 1'b1;
        #1;
        chk("rst_awvalid", 32'(AWVALID), 32'd0);
        chk("rst_wvalid", 32'(WVALID), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("rst_bready", 32'(BREADY), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        exp_aw.delete(); exp_w.delete(); exp_done.delete();
        repeat (2) @(negedge clk);
        ARESET = 1'b0;
        done_cyc = -2;
        break;
      end
      @(posedge clk); #1;
      k++;
    end
    if (rst_after == 0) chk("done_in_budget", 32'(done_cyc > 0), 32'd1);
    if (!legal) chk("reject_no_w", 32'(obs_strb.size()), 32'd0);
    @(posedge clk); #1;
    wr_valid = 1'b0; AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0;
  endtask

  task automatic chk_drained(input string nm);
    chk(nm, 32'(exp_aw.size() + exp_w.size() + exp_done.size()), 32'd0);
  endtask

  initial begin
    int dc, naw0, nd0;
    ARESET = 1'b1; cmd_valid = 1'b1; cmd_addr = 16'h0; cmd_len = 8'd0; cmd_size = 3'd0;
    wr_data = 32'h0; wr_valid = 1'b1; AWREADY = 1'b1; WREADY = 1'b1;
    BRESP = 2'b00; BVALID = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready0", 32'(cmd_ready), 32'd0);
    chk("rst_awvalid0", 32'(AWVALID), 32'd0);
    chk("rst_awburst0", 32'(AWBURST), 32'd1);
    chk("rst_wvalid0", 32'(WVALID), 32'd0);
    chk("rst_bready0", 32'(BREADY), 32'd0);
    chk("rst_done0", 32'(done_valid), 32'd0);
    cmd_valid = 1'b0; wr_valid = 1'b0; AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0;
    @(negedge clk);
    ARESET = 1'b0;
    @(posedge clk); #1;
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // single beat, everything ready
    naw0 = n_aw;
    do_cmd(16'h0010, 8'd0, 3'd2, 32'hA5A5A5A5, 0, 32'hFFFFFFFF, 0, 2'b00, 0, dc);
    chk("t1_latency", 32'(dc), 32'd3);
    chk("t1_strb", 32'(obs_strb.size() > 0 ? obs_strb[0] : 4'h0), 32'hF);
    chk("t1_one_aw", 32'(n_aw - naw0), 32'd1);
    chk_drained("t1_drained");

    // 8 beats, WREADY stalls, AWREADY late
    nd0 = n_done;
    do_cmd(16'h0100, 8'd7, 3'd2, 32'h10203040, 5, 32'b1101_1011_0110_1101_1011_0110_1101_1011,
           2, 2'b01, 0, dc);
    chk("t2_beats", 32'(obs_strb.size()), 32'd8);
    chk("t2_aw_after_w", 32'(aw_w_pos > 0), 32'd1);
    chk("t2_one_done", 32'(n_done - nd0), 32'd1);
    chk_drained("t2_drained");

    // narrow byte burst from an unaligned address
    do_cmd(16'h0002, 8'd3, 3'd0, 32'h11223344, 0, 32'hFFFFFFFF, 1, 2'b00, 0, dc);
    chk("t3_nbeats", 32'(obs_strb.size()), 32'd4);
    if (obs_strb.size() == 4) begin
      chk("t3_strb0", 32'(obs_strb[0]), 32'h4);
      chk("t3_strb1", 32'(obs_strb[1]), 32'h8);
      chk("t3_strb2", 32'(obs_strb[2]), 32'h1);
      chk("t3_strb3", 32'(obs_strb[3]), 32'h2);
    end
    chk_drained("t3_drained");

    // 4 KB crossing and oversize are rejected with no AXI activity
    naw0 = n_aw;
    do_cmd(16'h0FF8, 8'd3, 3'd2, 32'hDEAD0000, 0, 32'hFFFFFFFF, 0, 2'b00, 0, dc);
    chk("t4_reject_cycle", 32'(dc), 32'd1);
    do_cmd(16'h0000, 8'd0, 3'd3, 32'hBEEF0000, 0, 32'hFFFFFFFF, 0, 2'b00, 0, dc);
    chk("t5_reject_cycle", 32'(dc), 32'd1);
    chk("t45_no_aw", 32'(n_aw - naw0), 32'd0);
    chk_drained("t45_drained");

    // ends exactly on the 4 KB boundary: legal, slave answers SLVERR
    do_cmd(16'h0FF0, 8'd3, 3'd2, 32'h0BAD0001, 0, 32'hFFFFFFFF, 0, 2'b10, 0, dc);
    chk("t6_beats", 32'(obs_strb.size()), 32'd4);
    chk_drained("t6_drained");

    // missing B response times out, late BVALID ignored
    do_cmd(16'h0020, 8'd0, 3'd2, 32'h5A5A5A5A, 0, 32'hFFFFFFFF, -1, 2'b00, 0, dc);
    chk("t7_timeout_cycle", 32'(dc), 32'd18);
    nd0 = n_done;
    for (int i = 0; i < 3; i++) begin
      BVALID = 1'b1;
      @(negedge clk);
      chk("t7_late_bready", 32'(BREADY), 32'd0);
      @(posedge clk); #1;
    end
    BVALID = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("t7_no_extra_done", 32'(n_done - nd0), 32'd0);
    chk_drained("t7_drained");

    // reset after beat 2 of 4, then a fresh command
    nd0 = n_done;
    do_cmd(16'h0040, 8'd3, 3'd2, 32'hC0C0C0C0, 20, 32'hFFFFFFFF, 0, 2'b00, 2, dc);
    repeat (5) @(posedge clk);
    #1;
    chk("t8_no_done", 32'(n_done - nd0), 32'd0);
    chk("t8_idle_ready", 32'(cmd_ready), 32'd1);
    do_cmd(16'h0080, 8'd1, 3'd1, 32'h0F0F0F0F, 0, 32'hFFFFFFFF, 0, 2'b00, 0, dc);
    chk("t9_latency", 32'(dc), 32'd4);
    if (obs_strb.size() == 2) begin
      chk("t9_strb0", 32'(obs_strb[0]), 32'h3);
      chk("t9_strb1", 32'(obs_strb[1]), 32'hC);
    end else begin
      chk("t9_nbeats", 32'(obs_strb.size()), 32'd2);
    end
    chk_drained("t9_drained");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test want finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/axi_write_master.md
# axi_write_master

Parametrised AXI4 write-master engine that turns a command (address, length, size) plus a beat stream into a fully compliant INCR write burst on the AW/W/B channels. It is intended as the RTL write driver in front of the memory-mapped slave under verification, and as a reusable DMA write port. Compared with the existing bench driver, it overlaps the address and data phases and issues back-to-back beats with no idle cycles. It also generates narrow-transfer strobes, rejects illegal commands locally and times out on a missing write response.

## Interface
Parameters:
- ADDR_WIDTH, 16, byte-address width
- DATA_WIDTH, 32, W data width; power of two, 8..128
- TIMEOUT, 256, cycles waited in RESP for BVALID before forcing completion

Ports:
- clk  in  1  single clock, all logic on rising edge
- ARESET  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both high
- cmd_addr  in  ADDR_WIDTH  burst start address
- cmd_len  in  8  beats minus one (AWLEN encoding)
- cmd_size  in  3  bytes per beat = 2**cmd_size
- wr_data  in  DATA_WIDTH  beat data
- wr_valid / wr_ready  in / out  1  beat stream handshake
- done_valid  out  1  one-cycle completion pulse
- done_resp  out  2  BRESP, or local code (see Operation)
- done_timeout  out  1  qualifies done_valid: no B received
- AWADDR, AWLEN, AWSIZE  out  ADDR_WIDTH, 8, 3  address channel
- AWBURST  out  2  constant 2'b01 (INCR)
- AWVALID / AWREADY  out / in  1
- WDATA, WSTRB, WLAST  out  DATA_WIDTH, DATA_WIDTH/8, 1
- WVALID / WREADY  out / in  1
- BRESP  in  2;  BVALID / BREADY  in / out  1

## Operation
- States: IDLE, ACTIVE, RESP, REJECT.
- IDLE: cmd_ready=1. On handshake, the block validates the command:
  - illegal if 2**cmd_size > DATA_WIDTH/8, or if the burst crosses 4 KB, i.e. addr[11:0] + ((cmd_len+1) << cmd_size) > 4096;
  - illegal: go to REJECT.
  - legal: latch AW fields, set AWVALID, load beat counter = cmd_len, beat address = cmd_addr, go to ACTIVE.
- REJECT: one cycle. Issue done_valid=1, done_resp=2'b11, done_timeout=0, with no AXI activity. Return to IDLE.
- ACTIVE:
  - AWVALID is held until AWREADY, then dropped and the aw_done flag is set.
  - W is a pass-through: WVALID=wr_valid, wr_ready=WREADY, WDATA=wr_data. W beats are allowed before, with, or after AW.
  - WLAST=1 when beat counter = 0.
  - Each W handshake decrements the counter and adds 2**size to the beat address.
  - When the last beat is accepted and aw_done is set (or AW completes that same cycle), go to RESP.
- WSTRB: ((1 << 2**size) - 1) << (beat_addr mod (DATA_WIDTH/8)), aligned down to a 2**size boundary. With a full-width size, WSTRB is all ones.
- RESP:
  - BREADY=1 and the timeout counter increments.
  - On BVALID: done_valid=1, done_resp=BRESP, go to IDLE.
  - If the counter reaches TIMEOUT with no BVALID: done_valid=1, done_resp=2'b10, done_timeout=1, go to IDLE.
  - A late BVALID arriving in IDLE is ignored (BREADY=0).
- Reset value of every output is 0, except AWBURST=2'b01.
- cmd_ready is forced to 0 while ARESET is high.
- Reset mid-burst: all valids and readies drop asynchronously, no done pulse, state returns to IDLE.

## Timing
- Command accepted at edge N: AWVALID and W eligibility begin in cycle N+1.
- Beats stream at one per cycle while wr_valid and WREADY are both high. There are no bubbles between beats.
- Minimum latency for len=0 with all readies and BVALID high: AW and W handshakes at N+1, BREADY at N+2, done_valid at N+3.
- done_valid and done_resp are registered. done_valid is high for exactly one cycle per accepted command.
- AWVALID never depends combinationally on AWREADY. After assertion, AW fields are stable until the handshake.
- The next command can be accepted the cycle after done_valid.

## Structure
- Package axi_wm_pkg holds:
  - the state enum;
  - RESP_OKAY/EXOKAY/SLVERR/DECERR constants;
  - BURST_INCR;
  - the local REJECT code (2'b11).
- Sub-module axi_wstrb_gen: combinational, takes (beat_addr low bits, size) and produces WSTRB. It is parametrised by DATA_WIDTH.

## Test plan
- Single beat: addr 0x0010, len 0, size 2, data 0xA5A5A5A5, all readies high → one AW, one W with WLAST=1 and WSTRB=4'hF; done_resp=00 at N+3.
- 8-beat burst, random WREADY stalls, AWREADY delayed 5 cycles → 8 W handshakes with data in order; WLAST only on the 8th; AW seen after the first W beats; done once.
- Narrow size 0, addr 0x0002, len 3 → WSTRB sequence 4'b0100, 1000, 0001, 0010.
- Illegal commands:
  - addr 0x0FF8, len 3, size 2 (crosses 4 KB) → done_resp=11 next cycle, no AWVALID.
  - size 3 with DATA_WIDTH=32 → same result.
- BVALID held low, TIMEOUT=16 → done_valid 16 cycles after entering RESP, with done_resp=10 and done_timeout=1. A BVALID pulsed afterwards is ignored.
- ARESET asserted mid-burst after beat 2 of 4 → AWVALID, WVALID and BREADY low immediately, no done pulse. A fresh command afterwards completes with OKAY.
